// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature BCD / fever-alarm slice.
package temp_pkg;

  localparam int TEMP_X10_W       = 11;
  localparam int BCD_W            = 16;
  localparam int ALARM_HI_X10_DEF = 370;
  localparam int HYST_X10_DEF     = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_MULT    = 3'd2,
    ST_CONV    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 11-bit binary to four BCD digits, one bit per cycle.
module bin2bcd_seq
  import temp_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [TEMP_X10_W-1:0] bin,
  output logic [BCD_W-1:0]      bcd,
  output logic                  done
);

  localparam logic [3:0] LAST_ITER = 4'(TEMP_X10_W - 1);

  logic [TEMP_X10_W-1:0]       bin_sr;
  logic [BCD_W-1:0]            bcd_sr;
  logic [3:0]                  iter;
  logic                        busy;
  logic [BCD_W+TEMP_X10_W-1:0] adj;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    adj = {add3(bcd_sr), bin_sr};
  end

  // done is high during the final iteration so the caller can advance on the same edge.
  assign done = busy && (iter == LAST_ITER);
  assign bcd  = bcd_sr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      iter   <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      bin_sr <= bin;
      bcd_sr <= '0;
      iter   <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      bcd_sr <= adj[BCD_W+TEMP_X10_W-2 -: BCD_W];
      bin_sr <= {adj[TEMP_X10_W-2:0], 1'b0};
      iter   <= iter + 4'd1;
      if (iter == LAST_ITER) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/temp_bcd_alarm.sv
// Periodic sampler of the sensor reading: stability check, x10 scaling, BCD
// conversion and hysteretic fever alarm.
module temp_bcd_alarm
  import temp_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50_000_000,
  parameter int ALARM_HI_X10  = ALARM_HI_X10_DEF,
  parameter int HYST_X10      = HYST_X10_DEF,
  parameter int MAX_RETRY     = 15
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [7:0]            temp_int,
  input  logic [7:0]            temp_deci,
  output logic [TEMP_X10_W-1:0] temp_x10,
  output logic [BCD_W-1:0]      temp_bcd,
  output logic                  data_valid,
  output logic                  alarm,
  output state_t                fsm_state
);

  localparam int CNT_W   = $clog2(SAMPLE_PERIOD);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [TEMP_X10_W-1:0] ALARM_HI = TEMP_X10_W'(ALARM_HI_X10);
  localparam logic [TEMP_X10_W-1:0] ALARM_LO = TEMP_X10_W'(ALARM_HI_X10 - HYST_X10);

  logic [15:0]           sync1, sync2, sync3;
  logic                  stable;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  state_t                state;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [6:0]            int_q;
  logic [3:0]            deci_q;
  logic [3:0]            deci_clamp;
  logic [TEMP_X10_W-1:0] int_ext;
  logic [TEMP_X10_W-1:0] x10_calc;
  logic [TEMP_X10_W-1:0] x10_q;
  logic [BCD_W-1:0]      bcd_res;
  logic                  bcd_done;

  // The buses are asynchronous: sync1/sync2 resynchronise, sync3 is sync2 one cycle ago.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {temp_int, temp_deci};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign stable = (sync2 == sync3);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)               tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick       = (tick_cnt == TICK_LAST);
  assign deci_clamp = (sync2[7:0] > 8'd9) ? 4'd9 : sync2[3:0];
  assign int_ext    = {4'b0, int_q};
  assign x10_calc   = (int_ext << 3) + (int_ext << 1) + {7'b0, deci_q};
  assign fsm_state  = state;

  bin2bcd_seq u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (state == ST_MULT),
    .bin       (x10_calc),
    .bcd       (bcd_res),
    .done      (bcd_done)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      retry_cnt  <= '0;
      int_q      <= '0;
      deci_q     <= '0;
      x10_q      <= '0;
      temp_x10   <= '0;
      temp_bcd   <= '0;
      data_valid <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          retry_cnt <= '0;
          if (tick) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stable) begin
            int_q     <= sync2[14:8];
            deci_q    <= deci_clamp;
            retry_cnt <= '0;
            state     <= ST_MULT;
          end else if (retry_cnt == RETRY_LAST) begin
            retry_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
          end
        end
        ST_MULT: begin
          x10_q <= x10_calc;
          state <= ST_CONV;
        end
        ST_CONV: begin
          if (bcd_done) state <= ST_DONE;
        end
        ST_DONE: begin
          temp_x10   <= x10_q;
          temp_bcd   <= bcd_res;
          data_valid <= 1'b1;
          // Between the two thresholds the alarm keeps its previous value.
          if (x10_q >= ALARM_HI)     alarm <= 1'b1;
          else if (x10_q < ALARM_LO) alarm <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_bcd_alarm.sv
// Bench for temp_bcd_alarm: per-cycle reference model plus directed literal checks.
module tb_temp_bcd_alarm;
  import temp_pkg::*;

  localparam int PERIOD = 64;
  localparam int LAT    = 15;
  localparam int HI     = 370;
  localparam int LO     = 365;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  temp_int;
  logic [7:0]  temp_deci;
  logic [10:0] temp_x10;
  logic [15:0] temp_bcd;
  logic        data_valid;
  logic        alarm;
  state_t      fsm_state;

  temp_bcd_alarm #(.SAMPLE_PERIOD(PERIOD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .temp_int   (temp_int),
    .temp_deci  (temp_deci),
    .temp_x10   (temp_x10),
    .temp_bcd   (temp_bcd),
    .data_valid (data_valid),
    .alarm      (alarm),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset time base ----------------
  always #5 sys_clk = ~sys_clk;

  int pe;  // rising edges since reset release
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pe <= 0;
    else            pe <= pe + 1;
  end

  int tests = 0;
  int fails = 0;
  bit toggling = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at pe=%0d", name, act, act, exp, exp, pe);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [10:0] model_x10(input logic [7:0] ti, input logic [7:0] td);
    int v;
    v = (int'(ti) % 128) * 10 + ((td > 8'd9) ? 9 : int'(td));
    return 11'(v);
  endfunction

  function automatic logic [15:0] model_bcd(input int x);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  logic [10:0] exp_q[$];
  int          due_q[$];
  int          held_x10 = 0;
  int          held_bcd = 0;
  int          held_alarm = 0;

  // Scoreboard: every stable tick produces one update LAT cycles later.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      exp_q.delete();
      due_q.delete();
      held_x10   = 0;
      held_bcd   = 0;
      held_alarm = 0;
      chk("rst_dv", int'(data_valid), 0);
      chk("rst_x10", int'(temp_x10), 0);
      chk("rst_bcd", int'(temp_bcd), 0);
      chk("rst_alarm", int'(alarm), 0);
    end else begin
      if ((pe % PERIOD) == PERIOD - 1 && !toggling) begin
        exp_q.push_back(model_x10(temp_int, temp_deci));
        due_q.push_back(pe + LAT);
      end
      if (due_q.size() > 0 && due_q[0] == pe) begin
        void'(due_q.pop_front());
        held_x10 = int'(exp_q.pop_front());
        held_bcd = int'(model_bcd(held_x10));
        if (held_x10 >= HI)     held_alarm = 1;
        else if (held_x10 < LO) held_alarm = 0;
        chk("dv_pulse", int'(data_valid), 1);
      end else begin
        chk("dv_quiet", int'(data_valid), 0);
      end
      chk("x10", int'(temp_x10), held_x10);
      chk("bcd", int'(temp_bcd), held_bcd);
      chk("alarm", int'(alarm), held_alarm);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_temp(input int ti, input int td);
    #1;
    temp_int  = 8'(ti);
    temp_deci = 8'(td);
  endtask

  task automatic wait_dv(output int at_pe);
    at_pe = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (data_valid) begin
        at_pe = pe;
        return;
      end
    end
    chk("dv_timeout", 0, 1);
  endtask

  task automatic wait_offset(input int off);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if ((pe % PERIOD) == off) return;
    end
    chk("offset_timeout", 0, 1);
  endtask

  task automatic expect_out(input string name, input int x, input int b, input int a);
    chk({name, "_x10"}, int'(temp_x10), x);
    chk({name, "_bcd"}, int'(temp_bcd), b);
    chk({name, "_alarm"}, int'(alarm), a);
  endtask

  // ---------------- directed sequence ----------------
  int dv_pe;

  initial begin
    sys_rst_n = 1'b0;
    temp_int  = 8'd36;
    temp_deci = 8'd5;
    repeat (3) @(negedge sys_clk);
    expect_out("reset", 0, 16'h0000, 0);
    chk("reset_state", int'(fsm_state), int'(ST_IDLE));
    #1 sys_rst_n = 1'b1;

    // 36.5: first tick after release is at pe 63, result visible at pe 78
    wait_dv(dv_pe);
    chk("first_latency", dv_pe, PERIOD - 1 + LAT);
    expect_out("t365", 365, 16'h0365, 0);

    set_temp(37, 0);
    wait_dv(dv_pe);
    expect_out("t370", 370, 16'h0370, 1);
    set_temp(36, 6);
    wait_dv(dv_pe);
    expect_out("t366", 366, 16'h0366, 1);
    set_temp(36, 4);
    wait_dv(dv_pe);
    expect_out("t364", 364, 16'h0364, 0);

    set_temp(127, 9);
    wait_dv(dv_pe);
    expect_out("t1279", 1279, 16'h1279, 1);
    set_temp(20, 12);
    wait_dv(dv_pe);
    expect_out("t209", 209, 16'h0209, 0);
    set_temp(200, 0);
    wait_dv(dv_pe);
    expect_out("t720_msb", 720, 16'h0720, 1);

    // deci toggles every cycle across the whole capture window
    wait_offset(58);
    #1;
    toggling  = 1'b1;
    temp_int  = 8'd30;
    temp_deci = 8'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      #1 temp_deci = (temp_deci == 8'd3) ? 8'd4 : 8'd3;
    end
    toggling  = 1'b0;
    temp_deci = 8'd4;
    wait_offset(30);
    expect_out("toggle_hold", 720, 16'h0720, 1);
    chk("toggle_idle", int'(fsm_state), int'(ST_IDLE));
    wait_dv(dv_pe);
    expect_out("t304", 304, 16'h0304, 0);

    // reset pulse while converting
    set_temp(38, 0);
    wait_offset(PERIOD - 1);
    repeat (5) @(negedge sys_clk);
    chk("pre_reset_conv", int'(fsm_state), int'(ST_CONV));
    #1 sys_rst_n = 1'b0;
    #1;
    expect_out("mid_reset", 0, 16'h0000, 0);
    chk("mid_reset_state", int'(fsm_state), int'(ST_IDLE));
    chk("mid_reset_dv", int'(data_valid), 0);
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    wait_dv(dv_pe);
    chk("post_reset_latency", dv_pe, PERIOD - 1 + LAT);
    expect_out("t380", 380, 16'h0380, 1);

    repeat (5) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
